// File: rtl/mpu_cfg_seq.sv
// Configuration sequencer for the MPU9250: writes each (addr, data) table entry
// over the SPI byte engine, reads it back and retries until it verifies.
module mpu_cfg_seq #(
  parameter int unsigned NUM_REGS       = 8,
  parameter int unsigned STARTUP_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned CS_SETUP       = 2,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  output logic [7:0] tbl_idx,
  input  logic [7:0] tbl_addr,
  input  logic [7:0] tbl_data,
  output logic       spi_start,
  output logic [7:0] spi_tx,
  input  logic       spi_busy,
  input  logic       spi_finish,
  input  logic [7:0] spi_rx,
  output logic       cs_n,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] err_idx
);

  localparam int unsigned CNT_MAX0 = (STARTUP_CYCLES > GAP_CYCLES) ? STARTUP_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > CS_SETUP) ? CNT_MAX0 : CS_SETUP;
  localparam int unsigned CNT_W    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int unsigned RTY_W    = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_POWERUP, S_CS_LOW, S_BYTE0, S_BYTE1, S_CS_HIGH, S_CHECK, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               phase_q, phase_d;   // 0 = write frame, 1 = readback frame
  logic               sent_q, sent_d;     // current byte already handed to the engine
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [7:0]         rx_q, rx_d;
  logic [7:0]         tbl_idx_d, spi_tx_d, err_idx_d;
  logic               spi_start_d, cs_n_d, busy_d, done_d, error_d;
  logic [7:0]         byte0, byte1;
  logic               startup_end, setup_end, gap_end, last_entry, retry_left;
  logic               unused_addr_msb;

  assign unused_addr_msb = tbl_addr[7];

  assign byte0       = {phase_q, tbl_addr[6:0]};
  assign byte1       = phase_q ? 8'h00 : tbl_data;
  assign startup_end = (32'(cnt_q) + 32'd1) >= STARTUP_CYCLES;
  assign setup_end   = (32'(cnt_q) + 32'd1) >= CS_SETUP;
  assign gap_end     = (32'(cnt_q) + 32'd1) >= GAP_CYCLES;
  assign last_entry  = (32'(tbl_idx) + 32'd1) >= NUM_REGS;
  assign retry_left  = (32'(retry_q) + 32'd1) < MAX_RETRY;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    sent_d      = sent_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    rx_d        = rx_q;
    tbl_idx_d   = tbl_idx;
    spi_start_d = 1'b0;
    spi_tx_d    = spi_tx;
    cs_n_d      = cs_n;
    busy_d      = busy;
    done_d      = 1'b0;
    error_d     = error;
    err_idx_d   = err_idx;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          tbl_idx_d = 8'd0;
          retry_d   = RTY_W'(0);
          error_d   = 1'b0;
          busy_d    = 1'b1;
          phase_d   = 1'b0;
          cnt_d     = CNT_W'(0);
          state_d   = S_POWERUP;
        end
      end
      S_POWERUP: begin
        if (startup_end) begin
          cnt_d   = CNT_W'(0);
          cs_n_d  = 1'b0;
          state_d = S_CS_LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CS_LOW: begin
        if (setup_end) begin
          cnt_d   = CNT_W'(0);
          sent_d  = 1'b0;
          state_d = S_BYTE0;
          if (!spi_busy) begin
            spi_start_d = 1'b1;
            spi_tx_d    = byte0;
            sent_d      = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BYTE0: begin
        if (!sent_q) begin
          if (!spi_busy) begin
            spi_start_d = 1'b1;
            spi_tx_d    = byte0;
            sent_d      = 1'b1;
          end
        end else if (spi_finish) begin
          sent_d  = 1'b0;
          state_d = S_BYTE1;
        end
      end
      S_BYTE1: begin
        if (!sent_q) begin
          if (!spi_busy) begin
            spi_start_d = 1'b1;
            spi_tx_d    = byte1;
            sent_d      = 1'b1;
          end
        end else if (spi_finish) begin
          sent_d  = 1'b0;
          if (phase_q) rx_d = spi_rx;
          cs_n_d  = 1'b1;
          cnt_d   = CNT_W'(0);
          state_d = S_CS_HIGH;
        end
      end
      S_CS_HIGH: begin
        if (gap_end) begin
          cnt_d = CNT_W'(0);
          if (!phase_q) begin
            phase_d = 1'b1;
            cs_n_d  = 1'b0;
            state_d = S_CS_LOW;
          end else begin
            state_d = S_CHECK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        phase_d = 1'b0;
        if (rx_q == tbl_data) begin
          retry_d = RTY_W'(0);
          if (last_entry) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            tbl_idx_d = tbl_idx + 8'd1;
            cs_n_d    = 1'b0;
            state_d   = S_CS_LOW;
          end
        end else if (retry_left) begin
          retry_d = retry_q + RTY_W'(1);
          cs_n_d  = 1'b0;
          state_d = S_CS_LOW;
        end else begin
          error_d   = 1'b1;
          err_idx_d = tbl_idx;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; cs_n releases asynchronously on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      phase_q   <= 1'b0;
      sent_q    <= 1'b0;
      cnt_q     <= CNT_W'(0);
      retry_q   <= RTY_W'(0);
      rx_q      <= 8'd0;
      tbl_idx   <= 8'd0;
      spi_start <= 1'b0;
      spi_tx    <= 8'd0;
      cs_n      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_idx   <= 8'd0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      sent_q    <= sent_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      rx_q      <= rx_d;
      tbl_idx   <= tbl_idx_d;
      spi_start <= spi_start_d;
      spi_tx    <= spi_tx_d;
      cs_n      <= cs_n_d;
      busy      <= busy_d;
      done      <= done_d;
      error     <= error_d;
      err_idx   <= err_idx_d;
    end
  end

endmodule

// File: tb/tb_mpu_cfg_seq.sv
// Bench for mpu_cfg_seq: an SPI byte-engine/MPU model drives the DUT while a
// table-walk reference predicts the byte stream, frame count and outcome.
module tb_mpu_cfg_seq;

  localparam int NUM_REGS = 4;
  localparam int STARTUP  = 1000;
  localparam int GAP      = 8;
  localparam int SETUP    = 2;
  localparam int RETRY    = 3;
  localparam int BUDGET   = 30000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go  = 1'b0;
  logic [7:0] tbl_idx, tbl_addr, tbl_data, spi_tx, err_idx;
  logic       spi_start, cs_n, busy, done, error;
  logic       spi_busy   = 1'b0;
  logic       spi_finish = 1'b0;
  logic [7:0] spi_rx     = 8'h00;

  logic [7:0] ta [0:255];
  logic [7:0] td [0:255];
  assign tbl_addr = ta[tbl_idx];
  assign tbl_data = td[tbl_idx];

  mpu_cfg_seq #(
    .NUM_REGS(NUM_REGS), .STARTUP_CYCLES(STARTUP), .GAP_CYCLES(GAP),
    .CS_SETUP(SETUP), .MAX_RETRY(RETRY)
  ) dut (
    .clk(clk), .rst(rst), .go(go),
    .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .spi_start(spi_start), .spi_tx(spi_tx), .spi_busy(spi_busy),
    .spi_finish(spi_finish), .spi_rx(spi_rx),
    .cs_n(cs_n), .busy(busy), .done(done), .error(error), .err_idx(err_idx)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Engine / MPU model and monitor state
  bit         eng_active = 0, stall_en = 0, spur_en = 0, prev_cs = 1;
  int         eng_cnt = 0, stall_cnt = 0, fpos = 0, rd_no = 0;
  int         hi_cnt = 0, setup_cnt = 0, min_gap = 0, min_setup = 0;
  int         frames = 0, done_cnt = 0, viol = 0, max_idx = 0;
  logic [7:0] fb0 = 8'h00, fb1 = 8'h00, cur_tx = 8'h00, bad_val = 8'h00;
  logic [63:0] bad_mask = 64'd0;
  logic [7:0] mpu [0:127];
  logic [7:0] txlog [$];

  // Reference expectations
  logic [7:0] exp_tx [$];
  bit         exp_err;
  int         exp_eidx, exp_last, exp_frames;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      eng_active = 0; eng_cnt = 0; stall_cnt = 0; fpos = 0; prev_cs = 1; hi_cnt = 0;
      spi_busy = 1'b0; spi_finish = 1'b0; spi_rx = 8'h00;
    end else begin
      spi_finish = 1'b0;
      if (done) done_cnt++;
      if (busy && int'(tbl_idx) > max_idx) max_idx = int'(tbl_idx);
      if (!cs_n && prev_cs) begin
        if (frames > 0 && hi_cnt < min_gap) min_gap = hi_cnt;
        frames++; fpos = 0; setup_cnt = 0;
      end
      if (cs_n && !prev_cs) begin
        if (fpos != 2 || eng_active) viol++;
        hi_cnt = 0;
      end
      if (cs_n) hi_cnt++;
      prev_cs = cs_n;
      if (eng_active && spi_tx != cur_tx) viol++;
      // byte completion, with MPU register file behaviour on the second byte
      if (eng_active) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_active = 0; spi_finish = 1'b1; spi_rx = 8'hA5;
          if (fpos == 2) begin
            if (fb0[7]) begin
              spi_rx = bad_mask[rd_no[5:0]] ? bad_val : mpu[fb0[6:0]];
              rd_no++;
            end else begin
              mpu[fb0[6:0]] = fb1;
            end
          end
        end
      end
      if (spi_start) begin
        if (spi_busy || cs_n || eng_active || fpos > 1) viol++;
        if (fpos == 0) begin
          if (setup_cnt < min_setup) min_setup = setup_cnt;
          fb0 = spi_tx;
        end else begin
          fb1 = spi_tx;
        end
        txlog.push_back(spi_tx);
        cur_tx = spi_tx; fpos++; eng_active = 1; eng_cnt = 2 + int'($urandom_range(0, 4));
      end else if (!cs_n && fpos == 0) begin
        setup_cnt++;
      end
      if (stall_cnt > 0) stall_cnt--;
      else if (stall_en && !eng_active && !cs_n && $urandom_range(0, 3) == 0) stall_cnt = 20;
      if (spur_en && cs_n && !eng_active && $urandom_range(0, 5) == 0) spi_finish = 1'b1;
      spi_busy = eng_active || (stall_cnt > 0);
    end
  end

  // Table walk: write, read back, compare, retry up to RETRY attempts per entry
  task automatic build_model();
    int rd;
    bit ok;
    logic [7:0] rv;
    exp_tx.delete(); exp_err = 0; exp_eidx = 0; exp_last = 0; exp_frames = 0; rd = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_last = i; ok = 0;
      for (int a = 0; a < RETRY && !ok; a++) begin
        exp_tx.push_back({1'b0, ta[8'(i)][6:0]});
        exp_tx.push_back(td[8'(i)]);
        exp_tx.push_back({1'b1, ta[8'(i)][6:0]});
        exp_tx.push_back(8'h00);
        exp_frames += 2;
        rv = bad_mask[rd[5:0]] ? bad_val : td[8'(i)];
        rd++;
        if (rv == td[8'(i)]) ok = 1;
      end
      if (!ok) begin
        exp_err = 1; exp_eidx = i;
        break;
      end
    end
  endtask

  task automatic rand_table();
    for (int i = 0; i < 256; i++) begin
      ta[i] = 8'($urandom); td[i] = 8'($urandom);
    end
  endtask

  task automatic run_seq(input string tag, input bit spam);
    int n;
    build_model();
    txlog.delete(); frames = 0; done_cnt = 0; viol = 0; max_idx = 0;
    min_gap = 1 << 30; min_setup = 1 << 30; rd_no = 0;
    go = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
      go = spam;
      if (n == 1) begin
        check({tag, ":busy_on_go"}, 32'(busy), 32'd1);
        check({tag, ":error_cleared"}, 32'(error), 32'd0);
      end
    end while (cs_n && n < STARTUP + 50);
    check({tag, ":startup_cycles"}, 32'(n), 32'(STARTUP + 1));
    while (busy && n < BUDGET) begin
      @(negedge clk); n++;
    end
    check({tag, ":finished"}, 32'(busy), 32'd0);
    if (!done) go = 1'b0;
    @(negedge clk);
    go = 1'b0;
    repeat (30) @(negedge clk);
    check({tag, ":no_restart"}, 32'(busy), 32'd0);
    check({tag, ":done_pulses"}, 32'(done_cnt), exp_err ? 32'd0 : 32'd1);
    check({tag, ":error"}, 32'(error), 32'(exp_err));
    if (exp_err) check({tag, ":err_idx"}, 32'(err_idx), 32'(exp_eidx));
    check({tag, ":frames"}, 32'(frames), 32'(exp_frames));
    check({tag, ":bytes"}, 32'(txlog.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < txlog.size(); i++)
      check($sformatf("%s:tx[%0d]", tag, i), 32'(txlog[i]), 32'(exp_tx[i]));
    check({tag, ":protocol"}, 32'(viol), 32'd0);
    check({tag, ":gap_min"}, 32'(min_gap >= GAP), 32'd1);
    check({tag, ":setup_min"}, 32'(min_setup >= SETUP), 32'd1);
    check({tag, ":max_idx"}, 32'(max_idx), 32'(exp_last));
  endtask

  initial begin
    int n;
    rand_table();
    #1 rst = 1'b0;
    #1;
    check("reset:cs_n", 32'(cs_n), 32'd1);
    check("reset:outs", {8'(tbl_idx), 8'(spi_tx), 8'(err_idx), 4'd0,
                         spi_start, busy, done, error}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    ta[0] = 8'h6B; td[0] = 8'h01; ta[1] = 8'h1A; td[1] = 8'h03;
    bad_mask = 64'd0;
    run_seq("basic", 1'b0);
    check("basic:first_byte", 32'(txlog.size() > 0 ? txlog[0] : 8'h00), 32'h6B);
    check("basic:third_byte", 32'(txlog.size() > 2 ? txlog[2] : 8'h00), 32'hEB);

    bad_mask = 64'd1; bad_val = 8'h00;
    run_seq("retry_once", 1'b0);

    bad_mask = '1; bad_val = 8'hFF;
    run_seq("retry_fail", 1'b0);

    rand_table(); bad_mask = 64'd0; stall_en = 1;
    run_seq("stall", 1'b0);
    stall_en = 0;

    rand_table(); spur_en = 1;
    bad_mask = {$urandom, $urandom} & {$urandom, $urandom}; bad_val = 8'($urandom);
    run_seq("go_spam", 1'b1);
    spur_en = 0;

    // reset asserted while the second byte of the first frame is in flight
    bad_mask = 64'd0; done_cnt = 0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    while (!(fpos == 2 && eng_active) && n < BUDGET) begin
      @(negedge clk); n++;
    end
    check("abort:reached_byte1", 32'(fpos == 2 && eng_active), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort:cs_n", 32'(cs_n), 32'd1);
    check("abort:outs", {8'(tbl_idx), 8'(spi_tx), 8'(err_idx), 4'd0,
                         spi_start, busy, done, error}, 32'd0);
    @(negedge clk); @(negedge clk);
    check("abort:no_done", 32'(done_cnt), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    run_seq("after_abort", 1'b0);

    for (int k = 0; k < 3; k++) begin
      rand_table();
      stall_en = ($urandom_range(0, 1) == 1);
      spur_en  = ($urandom_range(0, 1) == 1);
      bad_mask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      bad_val  = 8'($urandom);
      run_seq($sformatf("rand%0d", k), $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
